// File: rtl/mul_iter_if.sv
//------------------------------------------------------------------------------
// Module      : mul_iter_if
// Description : Request/response handshake bundle for the iterative multiplier.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul_iter_if #(
    parameter int WIDTH = 32
);
    logic                 mul_valid;
    logic                 mul_ready;
    logic                 mul_signed;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 cancel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;

    // Requester side: issues operands, consumes the product.
    modport master (
        output mul_valid, mul_signed, x, y, cancel, out_ready,
        input  mul_ready, out_valid, result
    );

    // Multiplier side.
    modport slave (
        input  mul_valid, mul_signed, x, y, cancel, out_ready,
        output mul_ready, out_valid, result
    );
endinterface

`default_nettype wire

// File: rtl/mul_iter.sv
//------------------------------------------------------------------------------
// Module      : mul_iter
// Description : Radix-2 shift-add multiplier, fixed WIDTH-cycle latency, with
//               sign-magnitude handling of signed operands and flush support.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic   mul_clk,
    input  wire logic   reset,
    mul_iter_if.slave   bus
);
    localparam int              c_PROD_W   = 2 * WIDTH;
    localparam int              c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_PROD_W-1:0]    r_acc;
    logic [c_PROD_W-1:0]    r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic                   r_neg;
    logic [c_PROD_W-1:0]    r_result;

    logic [WIDTH-1:0]       w_x_abs;
    logic [WIDTH-1:0]       w_y_abs;
    logic [c_PROD_W-1:0]    w_acc_next;

    // 0x80..0 maps onto itself, which is the correct unsigned magnitude.
    assign w_x_abs = (bus.mul_signed && bus.x[WIDTH-1]) ? (~bus.x + WIDTH'(1)) : bus.x;
    assign w_y_abs = (bus.mul_signed && bus.y[WIDTH-1]) ? (~bus.y + WIDTH'(1)) : bus.y;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign bus.mul_ready = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.result    = r_result;

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!bus.cancel && bus.mul_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_x_abs};
                        r_mplier <= w_y_abs;
                        r_neg    <= bus.mul_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_state  <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (bus.cancel) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + c_CNT_W'(1);
                        // Result is registered from this cycle's sum, so no extra cycle.
                        if (r_count == c_LAST_CNT) begin
                            r_state  <= c_DONE;
                            r_result <= r_neg ? (~w_acc_next + c_PROD_W'(1)) : w_acc_next;
                        end
                    end
                end
                c_DONE: begin
                    if (bus.cancel || bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
//------------------------------------------------------------------------------
// Module      : tb_mul_iter
// Description : Directed self-checking bench for mul_iter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_iter;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mul_iter_if #(.WIDTH(WIDTH)) bus ();

    mul_iter #(.WIDTH(WIDTH)) dut (
        .mul_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then scramble the operands.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.x          = a;
        bus.y          = b;
        bus.mul_signed = s;
        bus.mul_valid  = 1'b1;
        tick();
        bus.mul_valid  = 1'b0;
        bus.x          = 32'hDEAD_BEEF;
        bus.y          = 32'hA5A5_5A5A;
        bus.mul_signed = ~s;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.mul_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", bus.mul_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.result !== 64'h0) begin
            n_err++; $display("FAIL reset_result: got %h want 0", bus.result);
        end
    endtask

    task automatic test_unsigned();
        int cyc;
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        n_cmp++;
        if (bus.mul_ready !== 1'b0) begin
            n_err++; $display("FAIL uns_busy_ready: got %b want 0", bus.mul_ready);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc != 32) begin
            n_err++; $display("FAIL uns_latency: got %0d want 32", cyc);
        end
        n_cmp++;
        if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin
            n_err++; $display("FAIL uns_result: got %h want fffffffe00000001", bus.result);
        end
        n_cmp++;
        if (bus.mul_ready !== 1'b0) begin
            n_err++; $display("FAIL uns_done_ready: got %b want 0", bus.mul_ready);
        end
        take();
        n_cmp++;
        if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL uns_handshake: got ready=%b valid=%b want 1/0", bus.mul_ready, bus.out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] vb [6] = '{32'd7, 32'h8000_0000, 32'd1, 32'd2, 32'd2, 32'h1234_5678};
        logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] ve [6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'h0000_0001_FFFF_FFFE,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            start(va[i], vb[i], vs[i]);
            wait_done(cyc);
            n_cmp++;
            if (cyc != 32) begin
                n_err++; $display("FAIL vec%0d_latency: got %0d want 32", i, cyc);
            end
            n_cmp++;
            if (bus.result !== ve[i]) begin
                n_err++; $display("FAIL vec%0d_result: got %h want %h", i, bus.result, ve[i]);
            end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        start(32'h0000_1234, 32'h10, 1'b0);
        wait_done(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.result !== 64'h1_2340 || bus.out_valid !== 1'b1 || bus.mul_ready !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0 || bus.result !== 64'h1_2340) begin
            n_err++; $display("FAIL bp_hold: got %0d unstable cycles, result %h want 0 / 12340", bad, bus.result);
        end
        // Request offered during the handshake edge must not be taken.
        bus.x = 32'd9; bus.y = 32'd9; bus.mul_signed = 1'b0; bus.mul_valid = 1'b1;
        take();
        bus.mul_valid = 1'b0;
        n_cmp++;
        if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus.mul_ready, bus.out_valid);
        end
        start(32'd6, 32'd7, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 32 || bus.result !== 64'd42) begin
            n_err++; $display("FAIL b2b_result: got %0d cycles result %h want 32 / 2a", cyc, bus.result);
        end
        take();
    endtask

    task automatic test_cancel();
        int cyc;
        int seen;
        start(32'd9, 32'd9, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        n_cmp++;
        if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL cancel_busy: got ready=%b valid=%b want 1/0", bus.mul_ready, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL cancel_no_valid: got %0d valid cycles want 0", seen);
        end
        start(32'd5, 32'd5, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 32 || bus.result !== 64'd25) begin
            n_err++; $display("FAIL cancel_next: got %0d cycles result %h want 32 / 19", cyc, bus.result);
        end
        take();

        start(32'd3, 32'd4, 1'b0);
        wait_done(cyc);
        bus.cancel = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd12) begin
            n_err++; $display("FAIL cancel_done: got ready=%b valid=%b result %h want 1/0/c",
                              bus.mul_ready, bus.out_valid, bus.result);
        end
        // Cancel in IDLE suppresses an accompanying request.
        bus.x = 32'd2; bus.y = 32'd2; bus.mul_valid = 1'b1;
        tick();
        bus.mul_valid = 1'b0; bus.cancel = 1'b0;
        n_cmp++;
        if (bus.mul_ready !== 1'b1) begin
            n_err++; $display("FAIL cancel_idle: got ready=%b want 1", bus.mul_ready);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        start(32'h1111, 32'h2222, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'h0) begin
            n_err++; $display("FAIL async_reset: got ready=%b valid=%b result %h want 1/0/0",
                              bus.mul_ready, bus.out_valid, bus.result);
        end
        tick();
        rst = 1'b0;
        tick();
        start(32'h1111, 32'h2222, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 32 || bus.result !== 64'h0246_8642) begin
            n_err++; $display("FAIL reset_next: got %0d cycles result %h want 32 / 2468642", cyc, bus.result);
        end
        take();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.mul_valid  = 1'b0;
        bus.mul_signed = 1'b0;
        bus.x          = '0;
        bus.y          = '0;
        bus.cancel     = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_unsigned();
        test_vectors();
        test_back_to_back();
        test_cancel();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
